// File: rtl/control_unit_v2.sv
// control_unit_v2: FSM controller for the 16-instruction accumulator processor.
// Drives IR/PC/accumulator/memory strobes, with a memory request/ready handshake
// and timeout trap, edge-qualified manual input, an output handshake and
// illegal-opcode trapping. All outputs are decoded from the current state and
// the live inputs; DisplayState mirrors the state code for the board LEDs.
module control_unit_v2 #(
  parameter int unsigned OP_W        = 4,
  parameter int unsigned MEM_HS      = 1,
  parameter int unsigned TIMEOUT     = 16,
  parameter int unsigned HALT_RESUME = 0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            Enter,
  input  logic [OP_W-1:0] IR,
  input  logic            Aeq0,
  input  logic            Apos,
  input  logic            mem_ready,
  input  logic            out_ack,
  output logic            IRload,
  output logic            JMPmux,
  output logic            PCload,
  output logic            Meminst,
  output logic            MemWr,
  output logic            Aload,
  output logic            Sub,
  output logic            mem_req,
  output logic [1:0]      Asel,
  output logic [2:0]      alu_op,
  output logic            out_valid,
  output logic            Halt,
  output logic            Error,
  output logic [4:0]      DisplayState
);

  typedef enum logic [4:0] {
    StStart  = 5'd0,
    StFetch  = 5'd1,
    StDecode = 5'd2,
    StLoad   = 5'd8,
    StStore  = 5'd9,
    StAdd    = 5'd10,
    StSub    = 5'd11,
    StIn     = 5'd12,
    StJz     = 5'd13,
    StJpos   = 5'd14,
    StHalt   = 5'd15,
    StAnd    = 5'd16,
    StOr     = 5'd17,
    StNot    = 5'd18,
    StJmp    = 5'd19,
    StOut    = 5'd20,
    StJneg   = 5'd21,
    StNop    = 5'd22,
    StError  = 5'd31
  } state_e;

  localparam logic [1:0] AselAlu = 2'b00;
  localparam logic [1:0] AselIn  = 2'b01;
  localparam logic [1:0] AselMem = 2'b10;

  localparam logic [2:0] AluAdd = 3'd0;
  localparam logic [2:0] AluSub = 3'd1;
  localparam logic [2:0] AluAnd = 3'd2;
  localparam logic [2:0] AluOr  = 3'd3;
  localparam logic [2:0] AluNot = 3'd4;

  // Counter only needs to reach TIMEOUT-1; with the trap disabled it may wrap harmlessly.
  localparam int unsigned   CntW      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT - 1);
  localparam bit            TimeoutEn = (TIMEOUT != 0);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            enter_q;

  logic       mem_rdy;
  logic       enter_rise;
  logic       op_illegal;
  logic [3:0] op_lo;
  logic       stall;
  logic       timeout;

  function automatic state_e op_to_state(input logic [3:0] op);
    case (op)
      4'd0:    return StLoad;
      4'd1:    return StStore;
      4'd2:    return StAdd;
      4'd3:    return StSub;
      4'd4:    return StIn;
      4'd5:    return StJz;
      4'd6:    return StJpos;
      4'd7:    return StHalt;
      4'd8:    return StAnd;
      4'd9:    return StOr;
      4'd10:   return StNot;
      4'd11:   return StJmp;
      4'd12:   return StOut;
      4'd13:   return StJneg;
      4'd14:   return StNop;
      default: return StError;
    endcase
  endfunction

  assign mem_rdy    = (MEM_HS != 0) ? mem_ready : 1'b1;
  assign enter_rise = Enter & ~enter_q;
  assign op_lo      = IR[3:0];
  // Any set bit above the 4-bit ISA field marks the opcode illegal.
  assign op_illegal = |(IR >> 4);

  assign stall   = ((state_q == StFetch) || (state_q == StLoad) || (state_q == StStore)) &
                   ~mem_rdy;
  // A ready in the same cycle suppresses the trap because stall is then low.
  assign timeout = TimeoutEn && stall && (cnt_q == CntMax);
  assign cnt_d   = stall ? cnt_q + 1'b1 : '0;

  assign DisplayState = state_q;

  // State, wait counter and Enter history registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StStart;
      cnt_q   <= '0;
      enter_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      enter_q <= Enter;
    end
  end

  // Next-state and datapath control decode.
  always_comb begin
    state_d   = state_q;
    IRload    = 1'b0;
    JMPmux    = 1'b0;
    PCload    = 1'b0;
    Meminst   = 1'b0;
    MemWr     = 1'b0;
    Aload     = 1'b0;
    Sub       = 1'b0;
    mem_req   = 1'b0;
    Asel      = AselAlu;
    alu_op    = AluAdd;
    out_valid = 1'b0;
    Halt      = 1'b0;
    Error     = 1'b0;

    case (state_q)
      StStart: state_d = StFetch;
      StFetch: begin
        mem_req = 1'b1;
        if (mem_rdy) begin
          IRload  = 1'b1;
          PCload  = 1'b1;
          state_d = StDecode;
        end
      end
      StDecode: begin
        Meminst = 1'b1;
        state_d = op_illegal ? StError : op_to_state(op_lo);
      end
      StLoad: begin
        mem_req = 1'b1;
        Meminst = 1'b1;
        Asel    = AselMem;
        if (mem_rdy) begin
          Aload   = 1'b1;
          state_d = StStart;
        end
      end
      StStore: begin
        mem_req = 1'b1;
        Meminst = 1'b1;
        MemWr   = 1'b1;
        if (mem_rdy) state_d = StStart;
      end
      StAdd: begin
        Aload   = 1'b1;
        alu_op  = AluAdd;
        state_d = StStart;
      end
      StSub: begin
        Aload   = 1'b1;
        Sub     = 1'b1;
        alu_op  = AluSub;
        state_d = StStart;
      end
      StAnd: begin
        Aload   = 1'b1;
        alu_op  = AluAnd;
        state_d = StStart;
      end
      StOr: begin
        Aload   = 1'b1;
        alu_op  = AluOr;
        state_d = StStart;
      end
      StNot: begin
        Aload   = 1'b1;
        alu_op  = AluNot;
        state_d = StStart;
      end
      StIn: begin
        Asel = AselIn;
        // Only a fresh press loads; a key already held on entry is ignored.
        if (enter_rise) begin
          Aload   = 1'b1;
          state_d = StStart;
        end
      end
      StOut: begin
        out_valid = 1'b1;
        if (out_ack) state_d = StStart;
      end
      StJz: begin
        JMPmux  = 1'b1;
        PCload  = Aeq0;
        state_d = StStart;
      end
      StJpos: begin
        JMPmux  = 1'b1;
        PCload  = Apos;
        state_d = StStart;
      end
      StJneg: begin
        JMPmux  = 1'b1;
        PCload  = ~Aeq0 & ~Apos;
        state_d = StStart;
      end
      StJmp: begin
        JMPmux  = 1'b1;
        PCload  = 1'b1;
        state_d = StStart;
      end
      StNop:  state_d = StStart;
      StHalt: begin
        Halt = 1'b1;
        if ((HALT_RESUME != 0) && enter_rise) state_d = StStart;
      end
      StError: Error = 1'b1;
      default: state_d = StError;
    endcase

    if (timeout) state_d = StError;
  end

endmodule

// File: tb/tb_control_unit_v2.sv
// Bench for control_unit_v2: instruction-level reference model checked every
// cycle, plus directed flows with literal expectations.
`timescale 1ns/1ps
module tb_control_unit_v2;

  localparam int unsigned OpW = 5;
  localparam int          To  = 4;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic           Enter = 1'b0;
  logic [OpW-1:0] IR = '0;
  logic           Aeq0 = 1'b0;
  logic           Apos = 1'b0;
  logic           mem_ready = 1'b0;
  logic           out_ack = 1'b0;
  logic IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, mem_req;
  logic [1:0] Asel;
  logic [2:0] alu_op;
  logic out_valid, Halt, Error;
  logic [4:0] DisplayState;

  int checks = 0;
  int errors = 0;

  control_unit_v2 #(
    .OP_W(OpW),
    .MEM_HS(1),
    .TIMEOUT(To),
    .HALT_RESUME(1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .Enter(Enter),
    .IR(IR),
    .Aeq0(Aeq0),
    .Apos(Apos),
    .mem_ready(mem_ready),
    .out_ack(out_ack),
    .IRload(IRload),
    .JMPmux(JMPmux),
    .PCload(PCload),
    .Meminst(Meminst),
    .MemWr(MemWr),
    .Aload(Aload),
    .Sub(Sub),
    .mem_req(mem_req),
    .Asel(Asel),
    .alu_op(alu_op),
    .out_valid(out_valid),
    .Halt(Halt),
    .Error(Error),
    .DisplayState(DisplayState)
  );

  always #5 clock = ~clock;

  logic [20:0] act_vec;
  assign act_vec = {IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, mem_req,
                    Asel, alu_op, out_valid, Halt, Error, DisplayState};

  // ---------------- reference model ----------------
  int   m_state = 0;
  int   m_cnt = 0;
  logic m_eq = 1'b0;
  int   op_tbl [16] = '{8, 9, 10, 11, 12, 13, 14, 15, 16, 17, 18, 19, 20, 21, 22, 31};

  function automatic bit is_wait(input int s);
    return (s == 1) || (s == 8) || (s == 9);
  endfunction

  function automatic int next_state();
    bit rise = Enter && !m_eq;
    if (is_wait(m_state) && !mem_ready && m_cnt == To - 1) return 31;
    case (m_state)
      0:       return 1;
      1:       return mem_ready ? 2 : 1;
      2:       return IR[4] ? 31 : op_tbl[IR[3:0]];
      8, 9:    return mem_ready ? 0 : m_state;
      12:      return rise ? 0 : 12;
      15:      return rise ? 0 : 15;
      20:      return out_ack ? 0 : 20;
      31:      return 31;
      default: return 0;
    endcase
  endfunction

  function automatic logic [20:0] exp_vec();
    logic ir_l = 0, jmp = 0, pc = 0, mi = 0, mw = 0, al = 0, sb = 0, mr = 0;
    logic ov = 0, h = 0, er = 0;
    logic [1:0] as = 2'd0;
    logic [2:0] op = 3'd0;
    case (m_state)
      1:  begin mr = 1; ir_l = mem_ready; pc = mem_ready; end
      2:  mi = 1;
      8:  begin mr = 1; mi = 1; as = 2'd2; al = mem_ready; end
      9:  begin mr = 1; mi = 1; mw = 1; end
      10: al = 1;
      11: begin al = 1; sb = 1; op = 3'd1; end
      16: begin al = 1; op = 3'd2; end
      17: begin al = 1; op = 3'd3; end
      18: begin al = 1; op = 3'd4; end
      12: begin as = 2'd1; al = Enter && !m_eq; end
      20: ov = 1;
      13: begin jmp = 1; pc = Aeq0; end
      14: begin jmp = 1; pc = Apos; end
      21: begin jmp = 1; pc = !Aeq0 && !Apos; end
      19: begin jmp = 1; pc = 1; end
      15: h = 1;
      31: er = 1;
      default: ;
    endcase
    return {ir_l, jmp, pc, mi, mw, al, sb, mr, as, op, ov, h, er, 5'(m_state)};
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_state <= 0;
      m_cnt   <= 0;
      m_eq    <= 1'b0;
    end else begin
      m_state <= next_state();
      m_cnt   <= (is_wait(m_state) && !mem_ready) ? m_cnt + 1 : 0;
      m_eq    <= Enter;
    end
  end

  // Every-cycle comparison, 3 ns after inputs change and 2 ns before the rising edge.
  always @(negedge clock) begin
    #3;
    checks++;
    if (act_vec !== exp_vec()) begin
      errors++;
      $display("FAIL model_compare t=%0t got %h want %h", $time, act_vec, exp_vec());
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic cyc(input logic en, input logic rdy, input logic ack, input logic [4:0] ir,
                     input logic z, input logic p);
    @(negedge clock);
    Enter = en; mem_ready = rdy; out_ack = ack; IR = ir; Aeq0 = z; Apos = p;
    #3;
  endtask

  // FETCH then DECODE with the given opcode; call from a START sample.
  task automatic issue(input logic [4:0] ir, input logic en, input logic z, input logic p);
    cyc(en, 1'b1, 1'b0, ir, z, p);
    cyc(en, 1'b1, 1'b0, ir, z, p);
  endtask

  task automatic do_reset();
    @(negedge clock);
    #1 reset = 1'b0;
    Enter = 0; mem_ready = 0; out_ack = 0; IR = '0; Aeq0 = 0; Apos = 0;
    #1 chk("reset_outputs", act_vec, 0);
    @(posedge clock);
    #1 reset = 1'b1;
  endtask

  initial begin
    int cnt;
    #2 chk("por_outputs", act_vec, 0);
    @(posedge clock);
    #1 reset = 1'b1;

    // LOAD with memory always ready: 0,1,2,8,0
    cyc(0, 1, 0, 5'd0, 0, 0); chk("load_start", DisplayState, 0);
    cyc(0, 1, 0, 5'd0, 0, 0); chk("load_fetch", DisplayState, 1);
    chk("load_irload_pcload", {IRload, PCload}, 2'b11);
    cyc(0, 1, 0, 5'd0, 0, 0); chk("load_decode", DisplayState, 2);
    cyc(0, 1, 0, 5'd0, 0, 0); chk("load_state", DisplayState, 8);
    chk("load_aload_asel", {Aload, Asel}, 3'b110);
    cyc(0, 1, 0, 5'd0, 0, 0); chk("load_back", DisplayState, 0);

    // FETCH stalls 3 cycles, ready on the 4th (counter at TIMEOUT-1: ready wins)
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 5'd14, 0, 0); chk("stall_fetch", DisplayState, 1); cnt += int'(IRload);
    end
    cyc(0, 1, 0, 5'd14, 0, 0); chk("stall_fetch_ready", DisplayState, 1); cnt += int'(IRload);
    chk("stall_irload_pulses", cnt, 1);
    cyc(0, 1, 0, 5'd14, 0, 0); chk("stall_decode", DisplayState, 2);
    cyc(0, 1, 0, 5'd14, 0, 0); chk("nop_state", DisplayState, 22);
    cyc(0, 1, 0, 5'd14, 0, 0); chk("nop_back", DisplayState, 0);

    // FETCH timeout: four cycles without ready -> ERROR, sticky
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 5'd0, 0, 0); chk("to_fetch", DisplayState, 1);
    end
    chk("to_no_irload", IRload, 0);
    cyc(1, 1, 1, 5'd0, 0, 0); chk("to_error", {Error, DisplayState}, 6'h3f);
    cyc(0, 1, 0, 5'd0, 0, 0); chk("to_sticky", DisplayState, 31);
    do_reset();
    cyc(0, 1, 0, 5'd4, 0, 0); chk("after_reset", DisplayState, 0);

    // IN with Enter already held on entry
    issue(5'd4, 1, 0, 0);
    cyc(1, 1, 0, 5'd4, 0, 0); chk("in_held", {DisplayState, Aload}, {5'd12, 1'b0});
    cyc(0, 1, 0, 5'd4, 0, 0); chk("in_released", Aload, 0);
    cyc(1, 1, 0, 5'd4, 0, 0); chk("in_edge", {Aload, Asel}, 3'b101);
    cyc(0, 1, 0, 5'd4, 0, 0); chk("in_back", DisplayState, 0);

    // JNEG with negative accumulator, then with zero
    issue(5'd13, 0, 0, 0);
    cyc(0, 1, 0, 5'd13, 0, 0); chk("jneg_taken", {DisplayState, PCload, JMPmux}, {5'd21, 2'b11});
    cyc(0, 1, 0, 5'd13, 1, 0); chk("jneg_back", DisplayState, 0);
    issue(5'd13, 0, 1, 0);
    cyc(0, 1, 0, 5'd13, 1, 0); chk("jneg_not_taken", {PCload, JMPmux}, 2'b01);
    cyc(0, 1, 0, 5'd13, 0, 0); chk("jneg_back2", DisplayState, 0);

    // OUT with ack arriving on the sixth cycle
    issue(5'd12, 0, 0, 0);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 0, 5'd12, 0, 0); cnt += int'(out_valid);
    end
    cyc(0, 1, 1, 5'd12, 0, 0); cnt += int'(out_valid);
    chk("out_valid_cycles", cnt, 6);
    cyc(0, 1, 0, 5'd12, 0, 0); chk("out_back", DisplayState, 0);

    // Other instructions, checked against the model; SUB pinned literally
    foreach (op_tbl[k]) begin
      if (k inside {2, 3, 5, 6, 8, 9, 10, 11, 1}) begin
        issue(5'(k), 0, 1, 1);
        cyc(0, 1, 0, 5'(k), 1, 1);
        if (k == 3) chk("sub_ctrl", {Aload, Sub, alu_op}, 5'b11001);
        if (k == 10) chk("not_aluop", alu_op, 3'd4);
        cyc(0, 1, 0, 5'(k), 0, 0); chk("instr_back", DisplayState, 0);
      end
    end

    // HALT resumes on an Enter rising edge
    issue(5'd7, 0, 0, 0);
    cyc(0, 1, 0, 5'd7, 0, 0); chk("halt_state", {Halt, DisplayState}, {1'b1, 5'd15});
    cyc(0, 1, 0, 5'd7, 0, 0); chk("halt_hold", DisplayState, 15);
    cyc(1, 1, 0, 5'd7, 0, 0); chk("halt_edge", Halt, 1);
    cyc(0, 1, 0, 5'd7, 0, 0); chk("halt_resume", DisplayState, 0);

    // Illegal opcodes
    issue(5'd15, 0, 0, 0);
    cyc(0, 1, 0, 5'd15, 0, 0); chk("op15_error", {Error, DisplayState}, 6'h3f);
    do_reset();
    cyc(0, 1, 0, 5'b10000, 0, 0); chk("after_reset2", DisplayState, 0);
    issue(5'b10000, 0, 0, 0);
    cyc(0, 1, 0, 5'b10000, 0, 0); chk("op_upper_error", DisplayState, 31);
    do_reset();

    // STORE timeout
    cyc(0, 1, 0, 5'd1, 0, 0);
    issue(5'd1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 5'd1, 0, 0); chk("store_wait", {MemWr, DisplayState}, {1'b1, 5'd9});
    end
    cyc(0, 0, 0, 5'd1, 0, 0); chk("store_timeout", DisplayState, 31);
    do_reset();

    // Async reset in the middle of a LOAD wait
    cyc(0, 1, 0, 5'd0, 0, 0);
    issue(5'd0, 0, 0, 0);
    cyc(0, 0, 0, 5'd0, 0, 0); chk("load_wait", {DisplayState, Aload}, {5'd8, 1'b0});
    cyc(0, 0, 0, 5'd0, 0, 0);
    #1 reset = 1'b0;
    #0.5 chk("midload_reset", act_vec, 0);
    @(posedge clock);
    #1 reset = 1'b1;
    cyc(0, 1, 0, 5'd0, 0, 0); chk("midload_restart", DisplayState, 0);
    cyc(0, 1, 0, 5'd0, 0, 0); chk("midload_fetch", DisplayState, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_unit_v2.md
Name: control_unit_v2

Overview:
- Parametrised successor to the accumulator-processor FSM controller. It drives IR/PC/accumulator/memory control signals for a 16-instruction ISA.
- Adds a memory request/ready handshake with timeout, edge-qualified manual input, an output handshake, and illegal-opcode trapping.
- Sits between the instruction register/status flags and the datapath. DisplayState goes to the board LEDs.

Parameters:
- OP_W, 4, opcode width (>=4); any nonzero bit above bit 3 makes the opcode illegal.
- MEM_HS, 1, 1 = wait on mem_ready; 0 = mem_ready internally forced to 1.
- TIMEOUT, 16, maximum cycles waiting on mem_ready before trapping; 0 disables the trap.
- HALT_RESUME, 0, 1 = an Enter rising edge in HALT returns to START.

Ports:
- clock in 1 system clock, rising edge.
- reset in 1 asynchronous, active-low reset.
- Enter in 1 manual-input confirm / halt resume.
- IR in OP_W opcode field.
- Aeq0 in 1 accumulator == 0.
- Apos in 1 accumulator > 0.
- mem_ready in 1 memory completed request.
- out_ack in 1 output device accepted value.
- IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub out 1 datapath controls.
- mem_req out 1 memory access request.
- Asel out 2 A source select: 00 ALU, 01 input, 10 memory.
- alu_op out 3 operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 NOT A.
- out_valid out 1 accumulator value offered to the output port.
- Halt out 1 in HALT.
- Error out 1 in ERROR.
- DisplayState out 5 current state code.

Behaviour:
- Reset (async, low): state=START, timeout counter=0, enter_q=0. Every output is 0.
- State codes: START 0, FETCH 1, DECODE 2, LOAD 8, STORE 9, ADD 10, SUB 11, IN 12, JZ 13, JPOS 14, HALT 15, AND 16, OR 17, NOT 18, JMP 19, OUT 20, JNEG 21, NOP 22, ERROR 31. DisplayState = state.
- Opcode to state: 0 LOAD, 1 STORE, 2 ADD, 3 SUB, 4 IN, 5 JZ, 6 JPOS, 7 HALT, 8 AND, 9 OR, 10 NOT, 11 JMP, 12 OUT, 13 JNEG, 14 NOP, 15 ERROR. Any OP_W upper bit set goes to ERROR.
- Outputs not listed below are 0 in each state.
- START: go to FETCH.
- FETCH: mem_req=1.
  - On mem_ready: IRload=1 and PCload=1 in that same cycle, then DECODE.
  - Otherwise stay in FETCH.
- DECODE: Meminst=1. Next state is taken from IR.
- LOAD: mem_req=1, Meminst=1, Asel=10. On mem_ready: Aload=1, then START.
- STORE: mem_req=1, Meminst=1, MemWr=1. On mem_ready: START.
- ADD / SUB / AND / OR / NOT: Aload=1, Asel=00, alu_op set per table. Sub=1 only in SUB. Then START.
- IN: Asel=01.
  - Aload=1 only in the cycle where Enter=1 and enter_q=0 (rising edge); then START.
  - Otherwise hold in IN.
  - enter_q is registered Enter, updated every cycle in all states.
- OUT: out_valid=1. Hold until out_ack=1, then START.
- Jumps (all go to START after one cycle; JMPmux=1 in each):
  - JZ: PCload=Aeq0.
  - JPOS: PCload=Apos.
  - JNEG: PCload = !Aeq0 & !Apos.
  - JMP: PCload=1.
  - PCload in jumps is combinational from the flags.
- NOP: go to START.
- HALT: Halt=1. If HALT_RESUME=1 and an Enter rising edge occurs, go to START; otherwise stay.
- ERROR: Error=1. Sticky; only reset exits.
- Timeout counter:
  - Counts each cycle spent in FETCH/LOAD/STORE with mem_ready=0; clears on any other cycle.
  - If TIMEOUT>0 and the counter reaches TIMEOUT-1 with mem_ready still 0, the next state is ERROR and no load/IR strobe fires.
  - mem_ready in that same cycle wins over the timeout.
- Simultaneous events:
  - Enter is ignored outside IN/HALT, but still updates enter_q.
  - out_ack outside OUT is ignored.
- Reset mid-operation: returns to START immediately; no strobe completes.

Test Plan:
- MEM_HS=1, mem_ready held 1, IR=0 (LOAD) → states 0,1,2,8,0. IRload/PCload pulse in FETCH; Aload=1 with Asel=10 in LOAD; total 4 cycles per instruction.
- FETCH with mem_ready low for 3 cycles, then high → DisplayState=1 for 4 cycles, IRload exactly 1 pulse. With TIMEOUT=4 and mem_ready low for 4 cycles → DisplayState=31, Error=1 until reset.
- IR=4 (IN), Enter already high on entry → Aload stays 0. Drop Enter, raise Enter → single Aload pulse with Asel=01, then START.
- IR=13 (JNEG): Aeq0=0, Apos=0 → PCload=1, JMPmux=1. Aeq0=1 → PCload=0.
- IR=12 (OUT), out_ack after 5 cycles → out_valid high 6 cycles, then state 0. IR=15, and IR=5'b10000 with OP_W=5, both → state 31.
- HALT_RESUME=1: IR=7 → Halt=1; Enter rising edge → START. Reset asserted in LOAD mid-wait → all outputs 0, state 0 asynchronously.
